// File: rtl/dc_sweep_pkg.sv
// Shared types and helpers for the DC bias-sweep sequencer.
package dc_sweep_pkg;

  localparam int unsigned DEF_CODE_W        = 12;
  localparam int unsigned DEF_ADC_W         = 16;
  localparam int unsigned DEF_CNT_W         = 8;
  localparam int unsigned DEF_SETTLE_CYCLES = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETTLE,
    ST_CONVERT,
    ST_WAIT_ADC,
    ST_EMIT,
    ST_DONE
  } sweep_state_e;

  // Unsigned add clamped to the all-ones value of a w-bit code (w <= 32).
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input int unsigned w);
    logic [32:0] sum;
    logic [32:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (33'(1) << w) - 33'(1);
    return (sum > lim) ? lim[31:0] : sum[31:0];
  endfunction

endpackage

// File: rtl/sweep_index_counter.sv
// One sweep axis: point index plus the matching saturating bias code.
module sweep_index_counter
  import dc_sweep_pkg::*;
#(
  parameter int unsigned CODE_W = DEF_CODE_W,
  parameter int unsigned CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_cfg,
  input  logic [CNT_W-1:0]  i_count,
  input  logic [CODE_W-1:0] i_start_code,
  input  logic [CODE_W-1:0] i_step,
  input  logic              i_inc,
  input  logic              i_clear,
  output logic [CNT_W-1:0]  o_idx,
  output logic [CODE_W-1:0] o_code,
  output logic              o_last_c
);

  logic [CNT_W-1:0]  r_idx;
  logic [CNT_W-1:0]  r_last_idx;
  logic [CODE_W-1:0] r_start;
  logic [CODE_W-1:0] r_step;
  logic [CODE_W-1:0] r_code;
  logic [CODE_W-1:0] w_code_inc;

  assign w_code_inc = CODE_W'(sat_add(32'(r_code), 32'(r_step), CODE_W));

  // A zero count still measures a single point.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx      <= '0;
      r_last_idx <= '0;
      r_start    <= '0;
      r_step     <= '0;
      r_code     <= '0;
    end else if (i_cfg) begin
      r_idx      <= '0;
      r_last_idx <= (i_count == '0) ? '0 : i_count - CNT_W'(1);
      r_start    <= i_start_code;
      r_step     <= i_step;
      r_code     <= i_start_code;
    end else if (i_clear) begin
      r_idx  <= '0;
      r_code <= r_start;
    end else if (i_inc) begin
      r_idx  <= r_idx + CNT_W'(1);
      r_code <= w_code_inc;
    end
  end

  assign o_idx    = r_idx;
  assign o_code   = r_code;
  assign o_last_c = (r_idx >= r_last_idx);

endmodule

// File: rtl/dc_sweep_sequencer.sv
// Nested gate/drain bias sweep: load DACs, settle, convert, stream one record per point.
module dc_sweep_sequencer
  import dc_sweep_pkg::*;
#(
  parameter int unsigned CODE_W        = DEF_CODE_W,
  parameter int unsigned ADC_W         = DEF_ADC_W,
  parameter int unsigned CNT_W         = DEF_CNT_W,
  parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [CODE_W-1:0] vg_start,
  input  logic [CODE_W-1:0] vg_step,
  input  logic [CNT_W-1:0]  vg_count,
  input  logic [CODE_W-1:0] vd_start,
  input  logic [CODE_W-1:0] vd_step,
  input  logic [CNT_W-1:0]  vd_count,
  output logic              busy,
  output logic              done,
  output logic [CODE_W-1:0] dac_vg,
  output logic [CODE_W-1:0] dac_vd,
  output logic              dac_load,
  output logic              adc_start,
  input  logic              adc_done,
  input  logic [ADC_W-1:0]  adc_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [CNT_W-1:0]  res_vg_idx,
  output logic [CNT_W-1:0]  res_vd_idx,
  output logic [ADC_W-1:0]  res_id
);

  localparam int unsigned SET_W = $clog2(SETTLE_CYCLES + 1);

  sweep_state_e     r_state;
  sweep_state_e     w_state_nxt;
  logic             w_cfg;
  logic             w_vd_inc;
  logic             w_vd_clear;
  logic             w_vg_inc;
  logic             w_capture;
  logic             w_handshake;
  logic             w_vg_last;
  logic             w_vd_last;
  logic [CNT_W-1:0] w_vg_idx;
  logic [CNT_W-1:0] w_vd_idx;
  logic [SET_W-1:0] r_settle_cnt;

  logic              r_busy;
  logic              r_done;
  logic              r_dac_load;
  logic              r_adc_start;
  logic              r_res_valid;
  logic [CNT_W-1:0]  r_res_vg_idx;
  logic [CNT_W-1:0]  r_res_vd_idx;
  logic [ADC_W-1:0]  r_res_id;

  sweep_index_counter #(.CODE_W(CODE_W), .CNT_W(CNT_W)) u_vg_cnt (
    .clk          (clk),
    .rst          (rst),
    .i_cfg        (w_cfg),
    .i_count      (vg_count),
    .i_start_code (vg_start),
    .i_step       (vg_step),
    .i_inc        (w_vg_inc),
    .i_clear      (1'b0),
    .o_idx        (w_vg_idx),
    .o_code       (dac_vg),
    .o_last_c     (w_vg_last)
  );

  sweep_index_counter #(.CODE_W(CODE_W), .CNT_W(CNT_W)) u_vd_cnt (
    .clk          (clk),
    .rst          (rst),
    .i_cfg        (w_cfg),
    .i_count      (vd_count),
    .i_start_code (vd_start),
    .i_step       (vd_step),
    .i_inc        (w_vd_inc),
    .i_clear      (w_vd_clear),
    .o_idx        (w_vd_idx),
    .o_code       (dac_vd),
    .o_last_c     (w_vd_last)
  );

  assign w_handshake = r_res_valid && res_ready;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state and axis control; abort beats every normal transition.
  always_comb begin
    w_state_nxt = r_state;
    w_cfg       = 1'b0;
    w_vd_inc    = 1'b0;
    w_vd_clear  = 1'b0;
    w_vg_inc    = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_cfg       = 1'b1;
          w_state_nxt = ST_LOAD;
        end
      end
      ST_LOAD:    w_state_nxt = abort ? ST_DONE : ST_SETTLE;
      ST_SETTLE: begin
        if (abort)                                        w_state_nxt = ST_DONE;
        else if (r_settle_cnt == SET_W'(SETTLE_CYCLES - 1)) w_state_nxt = ST_CONVERT;
      end
      ST_CONVERT: w_state_nxt = abort ? ST_DONE : ST_WAIT_ADC;
      ST_WAIT_ADC: begin
        if (abort) begin
          w_state_nxt = ST_DONE;
        end else if (adc_done) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (abort) begin
          w_state_nxt = ST_DONE;
        end else if (w_handshake) begin
          if (!w_vd_last) begin
            w_vd_inc    = 1'b1;
            w_state_nxt = ST_LOAD;
          end else if (!w_vg_last) begin
            w_vg_inc    = 1'b1;
            w_vd_clear  = 1'b1;
            w_state_nxt = ST_LOAD;
          end else begin
            w_state_nxt = ST_DONE;
          end
        end
      end
      ST_DONE:    w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are registered from the upcoming state so they align with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_dac_load   <= 1'b0;
      r_adc_start  <= 1'b0;
      r_res_valid  <= 1'b0;
      r_res_vg_idx <= '0;
      r_res_vd_idx <= '0;
      r_res_id     <= '0;
      r_settle_cnt <= '0;
    end else begin
      r_busy       <= (w_state_nxt != ST_IDLE) && (w_state_nxt != ST_DONE);
      r_done       <= (w_state_nxt == ST_DONE);
      r_dac_load   <= (w_state_nxt == ST_LOAD);
      r_adc_start  <= (w_state_nxt == ST_CONVERT);
      r_res_valid  <= (w_state_nxt == ST_EMIT);
      r_settle_cnt <= (r_state == ST_SETTLE && w_state_nxt == ST_SETTLE) ?
                      r_settle_cnt + SET_W'(1) : '0;
      if (w_capture) begin
        r_res_vg_idx <= w_vg_idx;
        r_res_vd_idx <= w_vd_idx;
        r_res_id     <= adc_data;
      end
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign dac_load   = r_dac_load;
  assign adc_start  = r_adc_start;
  assign res_valid  = r_res_valid;
  assign res_vg_idx = r_res_vg_idx;
  assign res_vd_idx = r_res_vd_idx;
  assign res_id     = r_res_id;

endmodule

// File: tb/tb_dc_sweep_sequencer.sv
// Bench for dc_sweep_sequencer: list-based sweep model, ADC responder and directed scenarios.
module tb_dc_sweep_sequencer;

  localparam int ADC_LAT = 5;

  logic        clk = 1'b0;
  logic        rst, start, abort, adc_done, res_ready;
  logic [11:0] vg_start, vg_step, vd_start, vd_step;
  logic [7:0]  vg_count, vd_count;
  logic [15:0] adc_data;
  logic        busy, done, dac_load, adc_start, res_valid;
  logic [11:0] dac_vg, dac_vd;
  logic [7:0]  res_vg_idx, res_vd_idx;
  logic [15:0] res_id;

  dc_sweep_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .vg_start(vg_start), .vg_step(vg_step), .vg_count(vg_count),
    .vd_start(vd_start), .vd_step(vd_step), .vd_count(vd_count),
    .busy(busy), .done(done), .dac_vg(dac_vg), .dac_vd(dac_vd),
    .dac_load(dac_load), .adc_start(adc_start), .adc_done(adc_done),
    .adc_data(adc_data), .res_valid(res_valid), .res_ready(res_ready),
    .res_vg_idx(res_vg_idx), .res_vd_idx(res_vd_idx), .res_id(res_id)
  );

  always #5 clk = ~clk;

  typedef struct { int vg; int vd; } load_t;
  typedef struct { int gi; int di; int id; } rec_t;

  load_t exp_loads[$];
  rec_t  exp_recs[$];

  int n_tests = 0, n_fail = 0;
  int cyc = 0;
  int n_recs, n_done, n_convs;
  int last_gi, last_di, last_id;
  int adc_base, conv_k;
  bit adc_pend = 0;
  int adc_due;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  always @(posedge clk) cyc++;

  // ADC model: adc_done pulses ADC_LAT cycles after adc_start, data = base + conversion number.
  always @(negedge clk) begin
    adc_done = 1'b0;
    if (adc_pend && cyc == adc_due) begin
      adc_done = 1'b1;
      adc_data = 16'(adc_base + conv_k);
      conv_k++;
      adc_pend = 0;
    end
    if (adc_start) begin
      adc_pend = 1;
      adc_due  = cyc + ADC_LAT;
    end
  end

  // Sweep model: every point in order with clamped codes, computed directly from the config.
  task automatic setup(input int vgs, input int vgst, input int vgc,
                       input int vds, input int vdst, input int vdc, input int base);
    int ng, nd;
    load_t l;
    rec_t  r;
    vg_start = 12'(vgs); vg_step = 12'(vgst); vg_count = 8'(vgc);
    vd_start = 12'(vds); vd_step = 12'(vdst); vd_count = 8'(vdc);
    adc_base = base; conv_k = 0;
    n_recs = 0; n_done = 0; n_convs = 0;
    exp_loads.delete();
    exp_recs.delete();
    ng = (vgc == 0) ? 1 : vgc;
    nd = (vdc == 0) ? 1 : vdc;
    for (int g = 0; g < ng; g++) begin
      for (int d = 0; d < nd; d++) begin
        l.vg = (vgs + g * vgst > 4095) ? 4095 : vgs + g * vgst;
        l.vd = (vds + d * vdst > 4095) ? 4095 : vds + d * vdst;
        exp_loads.push_back(l);
        r.gi = g; r.di = d; r.id = (base + g * nd + d) & 16'hffff;
        exp_recs.push_back(r);
      end
    end
  endtask

  // Per-cycle comparison of DAC loads, records and payload stability against the model.
  logic [31:0] prev_payload;
  bit          have_prev = 0;
  always @(negedge clk) begin
    load_t l;
    rec_t  r;
    #2;
    if (!rst) begin
      if (dac_load) begin
        if (exp_loads.size() == 0) fail("unexpected dac_load");
        else begin
          l = exp_loads.pop_front();
          check("dac_vg at load", dac_vg, l.vg);
          check("dac_vd at load", dac_vd, l.vd);
        end
      end
      if (adc_start) n_convs++;
      if (done) begin
        n_done++;
        check("busy during done", busy, 0);
      end
      if (res_valid) begin
        if (have_prev) check("payload stable", {res_vg_idx, res_vd_idx, res_id}, prev_payload);
        if (res_ready) begin
          have_prev = 0;
          if (exp_recs.size() == 0) fail("unexpected record");
          else begin
            r = exp_recs.pop_front();
            check("res_vg_idx", res_vg_idx, r.gi);
            check("res_vd_idx", res_vd_idx, r.di);
            check("res_id", res_id, r.id);
          end
          n_recs++;
          last_gi = res_vg_idx; last_di = res_vd_idx; last_id = res_id;
        end else begin
          have_prev = 1;
          prev_payload = {res_vg_idx, res_vd_idx, res_id};
        end
      end else have_prev = 0;
    end
  end

  function automatic logic sig_sel(input int sel);
    case (sel)
      0:       return dac_load;
      1:       return adc_start;
      2:       return res_valid;
      default: return done;
    endcase
  endfunction

  task automatic wait_for(input int sel, input int bound, input string name, output int k);
    k = 0;
    while (1) begin
      @(negedge clk);
      k++;
      if (sig_sel(sel)) break;
      if (k >= bound) begin
        fail({"timeout waiting for ", name});
        break;
      end
    end
  endtask

  task automatic start_sweep();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, orv;
    rst = 1'b1; start = 1'b0; abort = 1'b0; res_ready = 1'b1;
    adc_data = '0; adc_done = 1'b0; adc_base = 0; conv_k = 0;
    vg_start = '0; vg_step = '0; vg_count = '0; vd_start = '0; vd_step = '0; vd_count = '0;
    repeat (3) @(negedge clk);
    check("reset busy", busy, 0);
    check("reset done/load/adc/valid", {done, dac_load, adc_start, res_valid}, 0);
    check("reset dac codes", {dac_vg, dac_vd}, 0);
    check("reset res fields", {res_vg_idx, res_vd_idx, res_id}, 0);
    rst = 1'b0;

    // Nominal 2x3 sweep with a config change and extra start mid-sweep.
    setup(100, 50, 2, 0, 1000, 3, 16'h1234);
    check("model point count", exp_loads.size(), 6);
    check("model last vg", exp_loads[5].vg, 150);
    check("model last vd", exp_loads[5].vd, 2000);
    check("model rec3 idx", {exp_recs[3].gi, exp_recs[3].di}, {32'd1, 32'd0});
    start_sweep();
    check("cycle1 busy+load", {busy, dac_load}, 2'b11);
    check("cycle1 codes", {dac_vg, dac_vd}, {12'd100, 12'd0});
    wait_for(1, 100, "adc_start", w);
    check("adc_start cycle", 1 + w, 18);
    wait_for(2, 100, "res_valid", w);
    check("res_valid cycle", 18 + w, 24);
    wait_for(0, 100, "dac_load", w);
    check("next load cycle", 24 + w, 25);
    vg_start = 12'd999; start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_for(3, 3000, "done", w);
    vg_start = 12'd100;
    @(negedge clk);
    check("t1 records", n_recs, 6);
    check("t1 done pulses", n_done, 1);
    check("t1 conversions", n_convs, 6);
    check("t1 last record", {last_gi, last_di, last_id}, {32'd1, 32'd2, 32'h1239});
    check("t1 loads left", exp_loads.size(), 0);
    check("t1 idle", {busy, done}, 0);

    // Drain code saturation.
    setup(7, 0, 1, 4000, 100, 3, 16'h0100);
    check("model sat vd", exp_loads[1].vd, 4095);
    start_sweep();
    wait_for(3, 2000, "done", w);
    @(negedge clk);
    check("t2 records", n_recs, 3);
    check("t2 final dac_vd", dac_vd, 4095);
    check("t2 loads left", exp_loads.size(), 0);

    // Backpressure: record held 20 cycles, no DAC reload until accepted.
    setup(10, 1, 1, 20, 2, 2, 16'h0200);
    res_ready = 1'b0;
    start_sweep();
    wait_for(2, 200, "res_valid", w);
    orv = 0;
    repeat (20) begin
      @(negedge clk);
      orv |= (dac_load || !res_valid) ? 1 : 0;
    end
    check("t3 stalled load/valid", orv, 0);
    res_ready = 1'b1;
    @(negedge clk);
    check("t3 load after accept", dac_load, 1);
    check("t3 vd after accept", dac_vd, 22);
    wait_for(3, 2000, "done", w);
    @(negedge clk);
    check("t3 records", n_recs, 2);

    // Abort during SETTLE of point (0,1).
    setup(100, 50, 2, 0, 1000, 3, 16'h0300);
    start_sweep();
    wait_for(0, 100, "second dac_load", w);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    check("t4 done after abort", {done, busy}, 2'b10);
    abort = 1'b0;
    repeat (40) @(negedge clk);
    check("t4 conversions", n_convs, 1);
    check("t4 records", n_recs, 1);
    check("t4 done pulses", n_done, 1);
    check("t4 codes held", {dac_vg, dac_vd}, {12'd100, 12'd1000});

    // Reset while waiting on the ADC; the late adc_done must be ignored.
    setup(5, 1, 1, 5, 1, 1, 16'h0400);
    start_sweep();
    wait_for(1, 100, "adc_start", w);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    orv = 0;
    repeat (12) begin
      @(negedge clk);
      orv |= (busy || done || dac_load || adc_start || res_valid ||
              dac_vg != 0 || dac_vd != 0 || res_id != 0 ||
              res_vg_idx != 0 || res_vd_idx != 0) ? 1 : 0;
    end
    check("t5 outputs at reset values", orv, 0);
    check("t5 adc_done was delivered", conv_k, 1);
    check("t5 no record/done", {n_recs, n_done}, 0);

    // Zero counts measure one point; start coincident with done is ignored.
    setup(300, 9, 0, 400, 9, 0, 16'h0abc);
    start_sweep();
    wait_for(3, 2000, "done", w);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t6 start at done ignored", {busy, dac_load}, 0);
    repeat (3) @(negedge clk);
    check("t6 records", n_recs, 1);
    check("t6 done pulses", n_done, 1);
    check("t6 record", {last_gi, last_di, last_id}, {32'd0, 32'd0, 32'h0abc});
    check("t6 idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
